// File: rtl/cdm_pkg.sv
// cdm_pkg: shared constants and helpers for the carry-disregard multiplier.
// Stage count of the base pipeline and the half-product width.
package cdm_pkg;

   localparam int CDM_STAGES_BASE = 2;

   function automatic int cdm_hp_width(input int w);
      return w + w / 2;
   endfunction

endpackage

// File: rtl/cdm_half.sv
// cdm_half: a x b_half product whose K low columns are XOR-only (no carries).
// Columns at or above K are summed exactly.
module cdm_half
   import cdm_pkg::*;
#(
   parameter int W = 8,
   parameter int K = 0
) (
   input  logic [W-1:0]                 a_i,
   input  logic [W/2-1:0]               b_i,
   output logic [cdm_hp_width(W)-1:0]   p_o
);

   localparam int HW = cdm_hp_width(W);

   logic [HW-1:0] lo_b;
   logic [HW-1:0] hi_s;

   // Low columns toggle a parity bit; high columns accumulate weighted bits.
   always_comb begin
      lo_b = '0;
      hi_s = '0;
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W / 2; j++) begin
            if (a_i[i] & b_i[j]) begin
               if (i + j < K) begin
                  lo_b = lo_b ^ (HW'(1) << (i + j));
               end else begin
                  hi_s = hi_s + (HW'(1) << (i + j));
               end
            end
         end
      end
      p_o = hi_s | lo_b;
   end

endmodule

// File: rtl/cdm_pipe.sv
// cdm_pipe: pipelined approximate multiplier with valid/ready flow control.
// Define CDM_OUT_REG_EN to add a third output register stage.
module cdm_pipe
   import cdm_pkg::*;
#(
   parameter int W    = 8,
   parameter int K_LO = 6,
   parameter int K_HI = 2,
   parameter int TW   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic [TW-1:0]   in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  r,
   output logic [TW-1:0]   out_tag
);

   localparam int HW = cdm_hp_width(W);
   localparam int H  = W / 2;

   logic            adv;
   logic [HW-1:0]   plo_d;
   logic [HW-1:0]   phi_d;
   logic            v1_q;
   logic [HW-1:0]   plo_q;
   logic [HW-1:0]   phi_q;
   logic [TW-1:0]   tag1_q;
   logic            v2_q;
   logic [2*W-1:0]  r2_d;
   logic [2*W-1:0]  r2_q;
   logic [TW-1:0]   tag2_q;

   cdm_half #(.W(W), .K(K_LO)) u_lo (
      .a_i (a),
      .b_i (b[H-1:0]),
      .p_o (plo_d)
   );

   cdm_half #(.W(W), .K(K_HI)) u_hi (
      .a_i (a),
      .b_i (b[W-1:H]),
      .p_o (phi_d)
   );

   // One global advance: every stage moves together or holds together.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;
   assign r2_d     = ((2*W)'(phi_q) << H) + (2*W)'(plo_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         plo_q  <= '0;
         phi_q  <= '0;
         tag1_q <= '0;
      end else if (adv) begin
         v1_q   <= in_valid;
         plo_q  <= plo_d;
         phi_q  <= phi_d;
         tag1_q <= in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q   <= 1'b0;
         r2_q   <= '0;
         tag2_q <= '0;
      end else if (adv) begin
         v2_q   <= v1_q;
         r2_q   <= r2_d;
         tag2_q <= tag1_q;
      end
   end

`ifdef CDM_OUT_REG_EN
   logic            v3_q;
   logic [2*W-1:0]  r3_q;
   logic [TW-1:0]   tag3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3_q   <= 1'b0;
         r3_q   <= '0;
         tag3_q <= '0;
      end else if (adv) begin
         v3_q   <= v2_q;
         r3_q   <= r2_q;
         tag3_q <= tag2_q;
      end
   end

   assign out_valid = v3_q;
   assign r         = r3_q;
   assign out_tag   = tag3_q;
`else
   assign out_valid = v2_q;
   assign r         = r2_q;
   assign out_tag   = tag2_q;
`endif

endmodule

// File: tb/tb_cdm_pipe.sv
// tb_cdm_pipe: scoreboard bench, default-K DUT plus an exact (K=0) DUT.
// Both share stimulus; a column-count model supplies expected products.
module tb_cdm_pipe;

   localparam int W    = 8;
   localparam int K_LO = 6;
   localparam int K_HI = 2;
   localparam int TW   = 4;
`ifdef CDM_OUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      logic [15:0] ea;
      logic [15:0] eb;
      logic [3:0]  tag;
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [TW-1:0] in_tag;
   logic          out_ready;
   logic          ua_ir, ua_ov, ub_ir, ub_ov;
   logic [15:0]   ua_r, ub_r;
   logic [3:0]    ua_t, ub_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   lat_chk = 0;
   bit   rdy_rand = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cdm_pipe #(.W(W), .K_LO(K_LO), .K_HI(K_HI), .TW(TW)) u_apx (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ua_ir),
      .a(a), .b(b), .in_tag(in_tag), .out_valid(ua_ov),
      .out_ready(out_ready), .r(ua_r), .out_tag(ua_t)
   );

   cdm_pipe #(.W(W), .K_LO(0), .K_HI(0), .TW(TW)) u_exa (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ub_ir),
      .a(a), .b(b), .in_tag(in_tag), .out_valid(ub_ov),
      .out_ready(out_ready), .r(ub_r), .out_tag(ub_t)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Count bits per column; low columns keep only parity.
   function automatic longint half_m(int av, int bh, int k);
      longint acc = 0;
      for (int col = 0; col < 12; col++) begin
         int cnt = 0;
         for (int i = 0; i < 8; i++)
            if (col - i >= 0 && col - i < 4)
               cnt += ((av >> i) & 1) & ((bh >> (col - i)) & 1);
         acc += longint'(col < k ? cnt % 2 : cnt) << col;
      end
      return acc % 4096;
   endfunction

   function automatic logic [15:0] model(int av, int bv);
      longint s;
      s = (half_m(av, bv >> 4, K_HI) << 4) + half_m(av, bv & 15, K_LO);
      return 16'(s % 65536);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input int av, input int bv, input int tg,
                       input bit use_exp, input logic [15:0] ex,
                       output int waited);
      exp_t e;
      bit ok = 0;
      waited = 0;
      in_valid = 1'b1;
      a = W'(av);
      b = W'(bv);
      in_tag = TW'(tg);
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (ua_ir && !rst) begin
            e.ea = use_exp ? ex : model(av, bv);
            e.eb = 16'(av * bv);
            e.tag = 4'(tg);
            e.cyc = cyc;
            q.push_back(e);
            ok = 1;
         end
         tick();
         if (ok) break;
         waited++;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      rdy_rand = 0;
      out_ready = 1'b1;
      for (int n = 0; n < 200 && q.size() != 0; n++) tick();
      chk("drain_empty", q.size(), 0);
   endtask

   // Monitor: pops on every output transfer, independent of the driver.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ua_ov !== ub_ov) chk("valid_sync", ub_ov, ua_ov);
         if (ua_ov && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               e = q.pop_front();
               chk("r_apx", ua_r, e.ea);
               chk("tag_apx", ua_t, e.tag);
               chk("r_exact", ub_r, e.eb);
               chk("tag_exact", ub_t, e.tag);
               if (lat_chk) chk("latency", cyc - e.cyc, LAT);
            end
         end
      end
   end

   initial begin
      int w;
      logic [15:0] hr;
      logic [3:0]  ht;
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      in_tag = '0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", ua_ov, 0);
      chk("rst_r", ua_r, 0);
      chk("rst_tag", ua_t, 0);
      chk("rst_in_ready", ua_ir, 1);
      tick();
      rst = 1'b0;
      tick();

      // Directed values with hand-derived expectations.
      send(3, 8'h33, 1, 1, 16'd85, w);
      send(1, 1, 2, 1, 16'd1, w);
      send(255, 255, 3, 0, 16'd0, w);
      for (int i = 0; i < 3; i++) send(0, $urandom_range(0, 255), 4 + i, 1, 16'd0, w);
      drain();

      // Back-to-back stream, tags 0..15.
      lat_chk = 1;
      for (int i = 0; i < 16; i++) begin
         send($urandom_range(0, 255), $urandom_range(0, 255), i, 0, 16'd0, w);
         chk("stream_accept_wait", w, 0);
      end
      drain();
      lat_chk = 0;

      // Output stall with two beats in flight.
      out_ready = 1'b0;
      send($urandom_range(0, 255), $urandom_range(0, 255), 9, 0, 16'd0, w);
      send($urandom_range(0, 255), $urandom_range(0, 255), 10, 0, 16'd0, w);
      for (int n = 0; n < 8 && !ua_ov; n++) tick();
      chk("stall_fill", ua_ov, 1);
      hr = ua_r;
      ht = ua_t;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", ua_ir, 0);
         chk("stall_valid", ua_ov, 1);
         chk("stall_r", ua_r, hr);
         chk("stall_tag", ua_t, ht);
         tick();
      end
      drain();

      // Reset with beats in flight, then a fresh beat.
      send($urandom_range(1, 255), $urandom_range(1, 255), 11, 0, 16'd0, w);
      send($urandom_range(1, 255), $urandom_range(1, 255), 12, 0, 16'd0, w);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", ua_ov, 0);
      chk("async_rst_r", ua_r, 0);
      chk("async_rst_in_ready", ua_ir, 1);
      q.delete();
      tick();
      tick();
      rst = 1'b0;
      send(2, 2, 5, 1, 16'd4, w);
      drain();

      // Randomised traffic with random backpressure.
      rdy_rand = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         else send($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 15), 0, 16'd0, w);
      end
      drain();

      // Exhaustive sweep; the exact DUT must equal a*b everywhere.
      lat_chk = 1;
      for (int i = 0; i < 256; i++)
         for (int j = 0; j < 256; j++)
            send(i, j, i & 15, 0, 16'd0, w);
      drain();
      lat_chk = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
